branch_ctrl: RTL and testbench

- ID-stage branch sequencer for the five-stage MIPS pipeline. It sits beside the branch comparator and the NPC mux.
- Detects rs/rt read-after-write hazards against the E and M stages for beq/bgezal, stalls ID for exactly the required cycles, then samples the comparator result. It emits a one-cycle taken/link decision and keeps saturating branch statistics.
- Delay-slot semantics are kept: no flush is ever generated.

---
 rtl/branch_ctrl_pkg.sv | 22 ++
 rtl/branch_ctrl_if.sv | 29 ++
 rtl/branch_hazard_calc.sv | 49 ++++
 rtl/branch_ctrl.sv | 114 +++++++++++
 tb/tb_branch_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_ctrl_pkg.sv
// Shared decode constants, FSM encoding and stall-count defaults for the ID-stage branch sequencer.
package branch_ctrl_pkg;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int unsigned LD_STALL_E_DEF  = 2;
  localparam int unsigned ALU_STALL_E_DEF = 1;
  localparam int unsigned LD_STALL_M_DEF  = 1;

  localparam int unsigned STALL_W = 4;
  typedef logic [STALL_W-1:0] stall_t;

  function automatic stall_t stall_max(input stall_t a, input stall_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage pipeline view seen by the branch sequencer: decode/hazard inputs, stall and decision outputs.
interface branch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instr_d;
  logic             valid_d;
  logic [4:0]       e_wa;
  logic             e_we;
  logic             e_ld;
  logic [4:0]       m_wa;
  logic             m_we;
  logic             m_ld;
  logic             cmp_true;
  logic             stall_d;
  logic             br_taken;
  logic             link_we;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output instr_d, valid_d, e_wa, e_we, e_ld, m_wa, m_we, m_ld, cmp_true,
    input  stall_d, br_taken, link_we, br_cnt, taken_cnt
  );

  modport slave (
    input  instr_d, valid_d, e_wa, e_we, e_ld, m_wa, m_we, m_ld, cmp_true,
    output stall_d, br_taken, link_we, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_hazard_calc.sv
// Branch decode plus required ID stall count from rs/rt RAW hazards against the E and M stages.
module branch_hazard_calc
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned LD_STALL_E  = LD_STALL_E_DEF,
  parameter int unsigned ALU_STALL_E = ALU_STALL_E_DEF,
  parameter int unsigned LD_STALL_M  = LD_STALL_M_DEF
) (
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] e_wa,
  input  logic       e_we,
  input  logic       e_ld,
  input  logic [4:0] m_wa,
  input  logic       m_we,
  input  logic       m_ld,
  output logic       is_beq,
  output logic       is_bgezal,
  output stall_t     n
);

  function automatic stall_t operand_stall(
    input logic [4:0] r,
    input logic [4:0] ewa, input logic ewe, input logic eld,
    input logic [4:0] mwa, input logic mwe, input logic mld
  );
    if (r == 5'd0)                       return '0;
    else if (eld && ewe && (ewa == r))   return stall_t'(LD_STALL_E);
    else if (ewe && (ewa == r))          return stall_t'(ALU_STALL_E);
    else if (mld && mwe && (mwa == r))   return stall_t'(LD_STALL_M);
    else                                 return '0;
  endfunction

  stall_t rs_n;
  stall_t rt_n;

  always_comb begin
    is_beq    = (op == OP_BEQ);
    is_bgezal = (op == OP_REGIMM) && (rt == RT_BGEZAL);
    rs_n      = operand_stall(rs, e_wa, e_we, e_ld, m_wa, m_we, m_ld);
    rt_n      = operand_stall(rt, e_wa, e_we, e_ld, m_wa, m_we, m_ld);
    n         = '0;
    // bgezal's rt field is an opcode extension, not a register read
    if (is_beq)         n = stall_max(rs_n, rt_n);
    else if (is_bgezal) n = rs_n;
  end

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls for operand hazards, emits a one-cycle taken/link decision
// and keeps saturating branch statistics. Delay-slot semantics, so no flush is produced.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LD_STALL_E  = LD_STALL_E_DEF,
  parameter int unsigned ALU_STALL_E = ALU_STALL_E_DEF,
  parameter int unsigned LD_STALL_M  = LD_STALL_M_DEF
) (
  input logic           clk,
  input logic           reset,
  branch_ctrl_if.slave  bus
);

  logic             is_beq;
  logic             is_bgezal;
  logic             is_br;
  stall_t           n_req;
  stall_t           cnt;
  stall_t           cnt_nx;
  logic [0:0]       state;
  logic [0:0]       state_nx;
  logic             stall;
  logic             resolve;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic             unused_imm;

  assign unused_imm = ^bus.instr_d[15:0];

  branch_hazard_calc #(
    .LD_STALL_E  (LD_STALL_E),
    .ALU_STALL_E (ALU_STALL_E),
    .LD_STALL_M  (LD_STALL_M)
  ) u_hazard (
    .op        (bus.instr_d[31:26]),
    .rs        (bus.instr_d[25:21]),
    .rt        (bus.instr_d[20:16]),
    .e_wa      (bus.e_wa),
    .e_we      (bus.e_we),
    .e_ld      (bus.e_ld),
    .m_wa      (bus.m_wa),
    .m_we      (bus.m_we),
    .m_ld      (bus.m_ld),
    .is_beq    (is_beq),
    .is_bgezal (is_bgezal),
    .n         (n_req)
  );

  assign is_br = is_beq | is_bgezal;

  // Outputs are gated by reset so they read 0 the instant reset falls, even mid-stall.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    resolve  = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (bus.valid_d && is_br) begin
            if (n_req == '0) begin
              resolve = 1'b1;
            end else begin
              stall    = 1'b1;
              cnt_nx   = n_req - stall_t'(1);
              state_nx = WAIT;
            end
          end
        end
        WAIT: begin
          if (!bus.valid_d) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else if (cnt != '0) begin
            stall  = 1'b1;
            cnt_nx = cnt - stall_t'(1);
          end else begin
            resolve  = is_br;
            state_nx = IDLE;
          end
        end
        default: begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (resolve) begin
        if (~&br_cnt) br_cnt <= br_cnt + 1'b1;
        if (bus.cmp_true && (~&taken_cnt)) taken_cnt <= taken_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_d   = stall;
  assign bus.br_taken  = resolve & bus.cmp_true;
  assign bus.link_we   = resolve & is_bgezal;
  assign bus.br_cnt    = br_cnt;
  assign bus.taken_cnt = taken_cnt;

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed cycles push expected outputs, a monitor checks them.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic        link;
    logic [15:0] br;
    logic [15:0] tk;
  } rec_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  rec_t  sb[$];
  string names[$];
  event  sample_ev;

  branch_ctrl_if #(.CNT_W(16)) bus();

  branch_ctrl #(
    .CNT_W       (16),
    .LD_STALL_E  (2),
    .ALU_STALL_E (1),
    .LD_STALL_M  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) -> sample_ev;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] beq(input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000100, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] bgezal(input logic [4:0] rs);
    return {6'b000001, rs, 5'b10001, 16'h0004};
  endfunction

  localparam logic [31:0] NOP_ADD = 32'h0022_1820;
  localparam logic [31:0] BLTZ5   = 32'h04A0_0004;

  task automatic drive(
    input logic [31:0] ins, input logic v,
    input logic [4:0] ewa, input logic ewe, input logic eld,
    input logic [4:0] mwa, input logic mwe, input logic mld,
    input logic cmp
  );
    bus.instr_d  = ins;
    bus.valid_d  = v;
    bus.e_wa     = ewa;
    bus.e_we     = ewe;
    bus.e_ld     = eld;
    bus.m_wa     = mwa;
    bus.m_we     = mwe;
    bus.m_ld     = mld;
    bus.cmp_true = cmp;
  endtask

  task automatic expect_rec(
    input string nm, input logic s, input logic t, input logic l,
    input logic [15:0] br, input logic [15:0] tk
  );
    rec_t r;
    r.stall = s; r.taken = t; r.link = l; r.br = br; r.tk = tk;
    sb.push_back(r);
    names.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    forever begin
      @(sample_ev);
      if (sb.size() > 0) begin : check
        rec_t  e;
        rec_t  a;
        string nm;
        e = sb.pop_front();
        nm = names.pop_front();
        a.stall = bus.stall_d;
        a.taken = bus.br_taken;
        a.link  = bus.link_we;
        a.br    = bus.br_cnt;
        a.tk    = bus.taken_cnt;
        tests_run++;
        if (a !== e) begin
          tests_failed++;
          $display("FAIL %s: got stall=%0b taken=%0b link=%0b br_cnt=%h taken_cnt=%h, expected stall=%0b taken=%0b link=%0b br_cnt=%h taken_cnt=%h",
                   nm, a.stall, a.taken, a.link, a.br, a.tk, e.stall, e.taken, e.link, e.br, e.tk);
        end
      end
    end
  end

  initial begin : stim
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    drive(beq(5'd1, 5'd2), 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    expect_rec("reset_hold", 0, 0, 0, 16'd0, 16'd0);
    tick();
    reset = 1'b1;

    // beq without producers resolves in the same cycle
    drive(beq(5'd1, 5'd2), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    expect_rec("beq_nohaz", 0, 1, 0, 16'd0, 16'd0); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("beq_nohaz_cnt", 0, 0, 0, 16'd1, 16'd1); tick();

    // load in E feeding rs: two stall cycles, then not-taken
    drive(beq(5'd3, 5'd4), 1, 5'd3, 1, 1, 5'd0, 0, 0, 0);
    expect_rec("ldE_stall1", 1, 0, 0, 16'd1, 16'd1); tick();
    drive(beq(5'd3, 5'd4), 1, 5'd0, 0, 0, 5'd3, 1, 1, 0);
    expect_rec("ldE_stall2", 1, 0, 0, 16'd1, 16'd1); tick();
    drive(beq(5'd3, 5'd4), 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("ldE_resolve", 0, 0, 0, 16'd1, 16'd1); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("ldE_cnt", 0, 0, 0, 16'd2, 16'd1); tick();

    // ALU in E feeding bgezal: one stall, then taken + link
    drive(bgezal(5'd5), 1, 5'd5, 1, 0, 5'd0, 0, 0, 1);
    expect_rec("aluE_stall", 1, 0, 0, 16'd2, 16'd1); tick();
    drive(bgezal(5'd5), 1, 5'd0, 0, 0, 5'd5, 1, 0, 1);
    expect_rec("aluE_resolve", 0, 1, 1, 16'd2, 16'd1); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("aluE_cnt", 0, 0, 0, 16'd3, 16'd2); tick();

    // load in M feeding rt only
    drive(beq(5'd1, 5'd8), 1, 5'd0, 0, 0, 5'd8, 1, 1, 1);
    expect_rec("ldM_rt_stall", 1, 0, 0, 16'd3, 16'd2); tick();
    drive(beq(5'd1, 5'd8), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    expect_rec("ldM_rt_resolve", 0, 1, 0, 16'd3, 16'd2); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("ldM_cnt", 0, 0, 0, 16'd4, 16'd3); tick();

    // bgezal's rt field (17) is not a register read
    drive(bgezal(5'd9), 1, 5'd17, 1, 1, 5'd0, 0, 0, 0);
    expect_rec("bgezal_rt_ignored", 0, 0, 1, 16'd4, 16'd3); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("bgezal_nt_cnt", 0, 0, 0, 16'd5, 16'd3); tick();

    // $0 producers never stall
    drive(beq(5'd0, 5'd0), 1, 5'd0, 1, 1, 5'd0, 1, 1, 1);
    expect_rec("zero_reg", 0, 1, 0, 16'd5, 16'd3); tick();
    // REGIMM with a non-bgezal rt is not a branch
    drive(BLTZ5, 1, 5'd5, 1, 0, 5'd0, 0, 0, 1);
    expect_rec("regimm_other", 0, 0, 0, 16'd6, 16'd4); tick();
    // bubble carrying branch bits makes no decision
    drive(beq(5'd3, 5'd4), 0, 5'd3, 1, 1, 5'd0, 0, 0, 1);
    expect_rec("bubble", 0, 0, 0, 16'd6, 16'd4); tick();

    // external kill while waiting
    drive(beq(5'd3, 5'd4), 1, 5'd3, 1, 1, 5'd0, 0, 0, 1);
    expect_rec("kill_stall", 1, 0, 0, 16'd6, 16'd4); tick();
    drive(beq(5'd3, 5'd4), 0, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    expect_rec("kill_drop", 0, 0, 0, 16'd6, 16'd4); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    expect_rec("kill_cnt", 0, 0, 0, 16'd6, 16'd4); tick();

    // max over operands: rt load in E (2) beats rs load in M (1)
    drive(beq(5'd5, 5'd6), 1, 5'd6, 1, 1, 5'd5, 1, 1, 1);
    expect_rec("max_stall1", 1, 0, 0, 16'd6, 16'd4); tick();
    drive(beq(5'd5, 5'd6), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
    expect_rec("max_stall2", 1, 0, 0, 16'd6, 16'd4); tick();
    expect_rec("max_resolve", 0, 1, 0, 16'd6, 16'd4); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("max_cnt", 0, 0, 0, 16'd7, 16'd5); tick();

    // async reset during the first stall cycle
    drive(beq(5'd6, 5'd7), 1, 5'd6, 1, 1, 5'd0, 0, 0, 1);
    expect_rec("rst_pre", 1, 0, 0, 16'd7, 16'd5);
    @(negedge clk);
    #1;
    reset = 1'b0;
    expect_rec("rst_async", 0, 0, 0, 16'd0, 16'd0);
    #1;
    -> sample_ev;
    tick();
    expect_rec("rst_low", 0, 0, 0, 16'd0, 16'd0); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    reset = 1'b1;
    expect_rec("rst_release", 0, 0, 0, 16'd0, 16'd0); tick();

    // saturation: 65535 taken branches fill both counters, one more must not wrap
    for (int unsigned i = 0; i < 65535; i++) begin
      drive(beq(5'd1, 5'd2), 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
      expect_rec("sat_fill", 0, 1, 0, 16'(i), 16'(i));
      tick();
    end
    expect_rec("sat_extra", 0, 1, 0, 16'hFFFF, 16'hFFFF); tick();
    drive(NOP_ADD, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    expect_rec("sat_hold", 0, 0, 0, 16'hFFFF, 16'hFFFF); tick();

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d unchecked records, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
